// File: rtl/alu_int_seq.sv
// Sequential integer vector ALU: consumes N streamed signed elements per command and
// returns one reduction result (ADD, MUL, ARGMAX, or AVG via a restoring divider).
module alu_int_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_error
);
    localparam int AW = DATA_WIDTH + LEN_WIDTH;
    localparam int CW = $clog2(AW + 1);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_MUL    = 4'b0001;
    localparam logic [3:0] OP_ARGMAX = 4'b0100;
    localparam logic [3:0] OP_AVG    = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_OUT} state_t;

    state_t                 state_reg;
    logic [3:0]             op_reg;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [LEN_WIDTH-1:0]   cnt_reg;
    logic [LEN_WIDTH-1:0]   idx_reg;
    logic [DATA_WIDTH-1:0]  max_reg;
    logic [AW-1:0]          acc_reg;
    logic [AW-1:0]          quo_reg;
    logic [LEN_WIDTH-1:0]   rem_reg;
    logic                   neg_reg;
    logic [CW-1:0]          step_reg;

    logic [AW-1:0]          ext_data;
    logic [AW-1:0]          sum_next;
    logic [AW-1:0]          sum_mag;
    logic [DATA_WIDTH-1:0]  prod_next;
    logic                   take_max;
    logic                   last_elem;
    logic                   valid_op;
    logic [LEN_WIDTH:0]     shifted;
    logic [LEN_WIDTH:0]     diff;
    logic                   fits;
    logic [LEN_WIDTH-1:0]   rem_step;
    logic [AW-1:0]          quo_step;
    logic [AW-1:0]          quo_signed;
    logic [DATA_WIDTH-1:0]  acc_result;

    assign cmd_ready = (state_reg == S_IDLE);
    assign in_ready  = (state_reg == S_ACC);
    assign out_valid = (state_reg == S_OUT);

    // AVG sums in AW bits so the full N-element sum never overflows.
    assign ext_data  = {{LEN_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
    assign sum_next  = acc_reg + ext_data;
    assign sum_mag   = sum_next[AW-1] ? (~sum_next + AW'(1)) : sum_next;
    assign prod_next = acc_reg[DATA_WIDTH-1:0] * in_data;
    assign take_max  = (cnt_reg == '0) || ($signed(in_data) > $signed(max_reg));
    assign last_elem = (cnt_reg == len_reg - LEN_WIDTH'(1));
    assign valid_op  = (cmd_op == OP_ADD) || (cmd_op == OP_MUL) ||
                       (cmd_op == OP_ARGMAX) || (cmd_op == OP_AVG);

    // One restoring-division step: partial remainder stays below N, so LEN_WIDTH bits suffice.
    assign shifted    = {rem_reg, quo_reg[AW-1]};
    assign fits       = (shifted >= {1'b0, len_reg});
    assign diff       = shifted - {1'b0, len_reg};
    assign rem_step   = fits ? diff[LEN_WIDTH-1:0] : shifted[LEN_WIDTH-1:0];
    assign quo_step   = {quo_reg[AW-2:0], fits};
    assign quo_signed = neg_reg ? (~quo_step + AW'(1)) : quo_step;

    always_comb begin
        acc_result = '0;
        case (op_reg)
            OP_ADD:    acc_result = sum_next[DATA_WIDTH-1:0];
            OP_MUL:    acc_result = prod_next;
            OP_ARGMAX: acc_result = take_max ? DATA_WIDTH'(cnt_reg) : DATA_WIDTH'(idx_reg);
            default:   acc_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            max_reg    <= '0;
            acc_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            neg_reg    <= 1'b0;
            step_reg   <= '0;
            out_result <= '0;
            out_error  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_reg  <= cmd_op;
                        len_reg <= cmd_len;
                        cnt_reg <= '0;
                        idx_reg <= '0;
                        max_reg <= '0;
                        acc_reg <= (cmd_op == OP_MUL) ? AW'(1) : '0;
                        if (valid_op && cmd_len != '0) begin
                            out_error <= 1'b0;
                            state_reg <= S_ACC;
                        end else begin
                            out_result <= '0;
                            out_error  <= 1'b1;
                            state_reg  <= S_OUT;
                        end
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        cnt_reg <= cnt_reg + LEN_WIDTH'(1);
                        if (op_reg == OP_MUL)
                            acc_reg <= {{LEN_WIDTH{1'b0}}, prod_next};
                        else
                            acc_reg <= sum_next;
                        if (take_max) begin
                            max_reg <= in_data;
                            idx_reg <= cnt_reg;
                        end
                        if (last_elem) begin
                            if (op_reg == OP_AVG) begin
                                quo_reg   <= sum_mag;
                                rem_reg   <= '0;
                                neg_reg   <= sum_next[AW-1];
                                step_reg  <= '0;
                                state_reg <= S_DIV;
                            end else begin
                                out_result <= acc_result;
                                state_reg  <= S_OUT;
                            end
                        end
                    end
                end
                S_DIV: begin
                    quo_reg  <= quo_step;
                    rem_reg  <= rem_step;
                    step_reg <= step_reg + CW'(1);
                    if (step_reg == CW'(AW - 1)) begin
                        out_result <= quo_signed[DATA_WIDTH-1:0];
                        state_reg  <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_int_seq.sv
// Randomized self-checking bench for alu_int_seq against a plain-arithmetic reference model.
module tb_alu_int_seq;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_MUL    = 4'b0001;
    localparam logic [3:0] OP_ARGMAX = 4'b0100;
    localparam logic [3:0] OP_AVG    = 4'b1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_error;

    int checks = 0;
    int errors = 0;
    int elems[$];

    always #5 clk = ~clk;

    alu_int_seq #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_error(out_error)
    );

    // Fill the element queue: mode 0 full-range, 1 small values (ties), 2 tiny for MUL.
    task automatic fill(input int n, input int mode);
        elems.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: elems.push_back(int'($urandom));
                1: elems.push_back(int'($urandom_range(0, 7)) - 4);
                default: elems.push_back(int'($urandom_range(0, 9)) - 5);
            endcase
        end
    endtask

    // One full transaction. abort>0 pulses reset that many cycles after the last element.
    task automatic run_op(input logic [3:0] op, input int n, input bit gaps,
                          input int hold, input int abort);
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          t;
        int          lat;
        longint      s;
        longint      q;
        int          acc;
        int          best;

        exp_err = !(op == OP_ADD || op == OP_MUL || op == OP_ARGMAX || op == OP_AVG) || n == 0;
        exp_res = '0;
        exp_lat = (op == OP_AVG && !exp_err) ? 41 : 1;
        if (!exp_err) begin
            if (op == OP_ADD) begin
                acc = 0;
                foreach (elems[i]) acc += elems[i];
                exp_res = acc;
            end else if (op == OP_MUL) begin
                acc = 1;
                foreach (elems[i]) acc *= elems[i];
                exp_res = acc;
            end else if (op == OP_ARGMAX) begin
                best = 0;
                for (int i = 1; i < n; i++) if (elems[i] > elems[best]) best = i;
                exp_res = best;
            end else begin
                s = 0;
                foreach (elems[i]) s += longint'(elems[i]);
                q = s / longint'(n);
                exp_res = q[31:0];
            end
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = n[7:0];
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_timeout: cmd_ready=%0b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;

        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                in_valid = 1'b1;
                in_data  = elems[i];
                t = 0;
                while (!in_ready && t < 100) begin @(negedge clk); t++; end
                if (!in_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL in_timeout: in_ready=%0b required 1 at element %0d", in_ready, i);
                    in_valid = 1'b0;
                    return;
                end
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end

        if (abort > 0) begin
            repeat (abort - 1) @(negedge clk);
            reset = 1'b1;
            #1;
            checks++;
            if ({cmd_ready, in_ready, out_valid, out_result, out_error} !== {3'b100, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL abort_reset: rdy/in/ov=%0b%0b%0b res=%h err=%0b required 100 0 0",
                         cmd_ready, in_ready, out_valid, out_result, out_error);
            end
            @(negedge clk);
            reset = 1'b0;
            t = 0;
            for (int k = 0; k < 60; k++) begin
                if (out_valid) t++;
                @(negedge clk);
            end
            checks++;
            if (t !== 0) begin
                errors++;
                $display("FAIL abort_no_result: out_valid cycles=%0d required 0", t);
            end
            $display("txn op=%b n=%0d aborted after %0d cycles", op, n, abort);
            return;
        end

        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== exp_lat || !out_valid) begin
            errors++;
            $display("FAIL latency: got %0d cycles (out_valid=%0b) required %0d", lat, out_valid, exp_lat);
        end
        checks++;
        if (out_result !== exp_res || out_error !== exp_err) begin
            errors++;
            $display("FAIL result op=%b n=%0d: got %h err=%0b required %h err=%0b",
                     op, n, out_result, out_error, exp_res, exp_err);
        end
        $display("txn op=%b n=%0d result=%h err=%0b lat=%0d", op, n, out_result, out_error, lat);

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res || out_error !== exp_err ||
                cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: ov=%0b res=%h err=%0b crdy=%0b irdy=%0b required 1 %h %0b 0 0",
                         h, out_valid, out_result, out_error, cmd_ready, in_ready, exp_res, exp_err);
            end
        end
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%0b cmd_ready=%0b required 0 1", out_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, in_ready, out_valid, out_result, out_error} !== {3'b100, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: rdy/in/ov=%0b%0b%0b res=%h err=%0b required 100 0 0",
                     cmd_ready, in_ready, out_valid, out_result, out_error);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        elems = '{1, 2, 3, -10};
        run_op(OP_ADD, 4, 1'b0, 0, 0);
        elems = '{3, -1, 7, 7, 2};
        run_op(OP_ARGMAX, 5, 1'b0, 0, 0);
        elems = '{32'h10000, 32'h10000, 3};
        run_op(OP_MUL, 3, 1'b0, 0, 0);
        elems = '{-7, 0, 0};
        run_op(OP_AVG, 3, 1'b0, 0, 0);
        elems = '{-9};
        run_op(OP_AVG, 1, 1'b0, 0, 0);
        elems = '{-9};
        run_op(OP_ARGMAX, 1, 1'b0, 0, 0);
    endtask

    task automatic test_errors();
        elems.delete();
        run_op(4'b0010, 3, 1'b0, 4, 0);
        run_op(OP_ADD, 0, 1'b0, 4, 0);
        run_op(OP_AVG, 0, 1'b0, 2, 0);
    endtask

    task automatic test_hold();
        fill(5, 0);
        run_op(OP_ADD, 5, 1'b0, 10, 0);
        fill(4, 0);
        run_op(OP_AVG, 4, 1'b0, 10, 0);
    endtask

    task automatic test_abort();
        elems = '{-7, 0, 0};
        run_op(OP_AVG, 3, 1'b0, 0, 10);
        elems = '{5};
        run_op(OP_ADD, 1, 1'b0, 0, 0);
        fill(3, 0);
        run_op(OP_ADD, 3, 1'b0, 0, 3);
    endtask

    task automatic test_max_len();
        fill(255, 0);
        run_op(OP_ADD, 255, 1'b0, 0, 0);
        fill(255, 0);
        run_op(OP_AVG, 255, 1'b1, 0, 0);
        fill(255, 1);
        run_op(OP_ARGMAX, 255, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0] ops[4];
        int         n;
        int         k;
        ops = '{OP_ADD, OP_MUL, OP_ARGMAX, OP_AVG};
        for (int r = 0; r < 48; r++) begin
            k = $urandom_range(0, 3);
            n = $urandom_range(1, 16);
            fill(n, (ops[k] == OP_MUL) ? 2 : (ops[k] == OP_ARGMAX ? int'($urandom_range(0, 1)) : 0));
            run_op(ops[k], n, 1'($urandom), $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_hold();
        test_abort();
        test_max_len();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
